// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide scheduler: op codes, FSM states, default latencies.
package md_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_sched_if.sv
// E-stage request, D-stage hazard input and HI/LO/busy/stall results of the md scheduler.
interface md_sched_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        md_use_d;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, md_op, src_a, src_b, md_use_d,
                  input  busy, stall, hi, lo);
  modport slave  (input  start, md_op, src_a, src_b, md_use_d,
                  output busy, stall, hi, lo);
endinterface

// File: rtl/md_div.sv
// Combinational 32-bit divider on latched operands; signed mode truncates toward zero,
// remainder follows the dividend sign. Zero divisor yields 0 (the caller suppresses the write).
module md_div (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sgn,
  output logic [31:0] q,
  output logic [31:0] r
);
  logic        neg_a, neg_b;
  logic [31:0] ua, ub, uq, ur;

  always_comb begin
    neg_a = sgn & a[31];
    neg_b = sgn & b[31];
    ua    = neg_a ? (~a + 32'd1) : a;
    ub    = neg_b ? (~b + 32'd1) : b;
    uq    = 32'd0;
    ur    = 32'd0;
    if (ub != 32'd0) begin
      uq = ua / ub;
      ur = ua % ub;
    end
    // 0x80000000 / -1 wraps back to 0x80000000 through the negate
    q = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
    r = neg_a ? (~ur + 32'd1) : ur;
  end
endmodule

// File: rtl/md_sched.sv
// Multicycle mult/div scheduler owning HI/LO; raises busy/stall while an op is in flight.
// Define MD_SCHED_DIV_EN to compile in DIV/DIVU; otherwise they are no-ops.
module md_sched
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic       clk,
  input logic       reset,
  md_sched_if.slave bus
);
  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

  md_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] a_q, b_q, hi_q, lo_q;
  logic [31:0] a_d, b_d, hi_d, lo_d;
  md_op_e      op_q, op_d, op_in;
  logic        mc_op, in_div, busy;
  logic        sx;
  logic [63:0] ea, eb, prod;
  logic [31:0] res_hi, res_lo;
  logic        res_wr;

  assign op_in  = md_op_e'(bus.md_op);
  assign in_div = (op_in == OP_DIV) || (op_in == OP_DIVU);

`ifdef MD_SCHED_DIV_EN
  assign mc_op = (op_in == OP_MULT) || (op_in == OP_MULTU) || in_div;
`else
  assign mc_op = (op_in == OP_MULT) || (op_in == OP_MULTU);
`endif

  // Low 64 bits of the sign/zero-extended product serve both MULT and MULTU
  assign sx   = (op_q == OP_MULT);
  assign ea   = {{32{sx & a_q[31]}}, a_q};
  assign eb   = {{32{sx & b_q[31]}}, b_q};
  assign prod = ea * eb;

`ifdef MD_SCHED_DIV_EN
  logic        is_div;
  logic [31:0] dq, dr;
  assign is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);
  md_div u_div (.a(a_q), .b(b_q), .sgn(op_q == OP_DIV), .q(dq), .r(dr));
  assign res_hi = is_div ? dr : prod[63:32];
  assign res_lo = is_div ? dq : prod[31:0];
  assign res_wr = !(is_div && (b_q == 32'd0));
`else
  assign res_hi = prod[63:32];
  assign res_lo = prod[31:0];
  assign res_wr = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q == S_IDLE) begin
      if (bus.start) begin
        if (mc_op) begin
          a_d     = bus.src_a;
          b_d     = bus.src_b;
          op_d    = op_in;
          cnt_d   = in_div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
          state_d = S_BUSY;
        end else if (op_in == OP_MTHI) begin
          hi_d = bus.src_a;
        end else if (op_in == OP_MTLO) begin
          lo_d = bus.src_a;
        end
      end
    end else begin
      if (cnt_q == '0) begin
        state_d = S_IDLE;
        if (res_wr) begin
          hi_d = res_hi;
          lo_d = res_lo;
        end
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_MULT;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy      = (state_q == S_BUSY);
  assign bus.busy  = busy;
  assign bus.stall = bus.md_use_d & (busy | (bus.start & mc_op));
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched; inputs driven and outputs sampled on the falling edge.
module tb_md_sched;
  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  md_sched_if bus ();

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = op; bus.src_a = a; bus.src_b = b;
    #1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
  endtask

  // Counts busy cycles from the current sample point; bounded so a stuck busy cannot hang.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.busy) break;
      n++;
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.start = 1'b0; bus.md_op = 3'd0; bus.src_a = '0; bus.src_b = '0; bus.md_use_d = 1'b1;
    #22;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
    checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
    @(negedge clk);
    reset = 1'b1;
    bus.md_use_d = 1'b0;
  endtask

  task automatic test_mult;
    int n;
    issue(3'd0, 32'hFFFFFFFE, 32'd3);
    count_busy(n);
    checks++; if (n !== 5) begin failures++; $display("FAIL mult_busy got=%0d exp=5", n); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFFFFFA) begin failures++; $display("FAIL mult_lo got=%h exp=fffffffa", bus.lo); end
    issue(3'd1, 32'hFFFFFFFF, 32'd2);
    count_busy(n);
    checks++; if (n !== 5) begin failures++; $display("FAIL multu_busy got=%0d exp=5", n); end
    checks++; if (bus.hi !== 32'h1) begin failures++; $display("FAIL multu_hi got=%h exp=00000001", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_lo got=%h exp=fffffffe", bus.lo); end
  endtask

  task automatic test_div;
`ifdef MD_SCHED_DIV_EN
    int n;
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    count_busy(n);
    checks++; if (n !== 10) begin failures++; $display("FAIL div_busy got=%0d exp=10", n); end
    checks++; if (bus.lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", bus.lo); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", bus.hi); end
    issue(3'd3, 32'd7, 32'd0);
    count_busy(n);
    checks++; if (n !== 10) begin failures++; $display("FAIL divz_busy got=%0d exp=10", n); end
    checks++; if (bus.lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL divz_lo got=%h exp=fffffffd", bus.lo); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL divz_hi got=%h exp=ffffffff", bus.hi); end
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    count_busy(n);
    checks++; if (bus.lo !== 32'h80000000) begin failures++; $display("FAIL divovf_lo got=%h exp=80000000", bus.lo); end
    checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL divovf_hi got=%h exp=0", bus.hi); end
`else
    bus.md_use_d = 1'b1;
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = 3'd2; bus.src_a = 32'hFFFFFFF9; bus.src_b = 32'd2;
    #1;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL nodiv_stall got=%b exp=0", bus.stall); end
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL nodiv_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.hi !== 32'h1) begin failures++; $display("FAIL nodiv_hi got=%h exp=00000001", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFFFFFE) begin failures++; $display("FAIL nodiv_lo got=%h exp=fffffffe", bus.lo); end
    bus.md_use_d = 1'b0;
`endif
  endtask

  task automatic test_stall;
    int sc = 0;
    bus.md_use_d = 1'b1;
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = 3'd0; bus.src_a = 32'd3; bus.src_b = 32'd4;
    #1;
    if (bus.stall) sc++;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (!bus.stall) break;
      sc++;
      @(negedge clk); #1;
    end
    checks++; if (sc !== 6) begin failures++; $display("FAIL stall_cycles got=%0d exp=6", sc); end
    checks++; if (bus.lo !== 32'd12) begin failures++; $display("FAIL stall_mflo got=%h exp=0000000c", bus.lo); end
    checks++; if (bus.hi !== 32'd0) begin failures++; $display("FAIL stall_hi got=%h exp=0", bus.hi); end
    bus.md_use_d = 1'b0;
  endtask

  task automatic test_mthi;
    int n;
    bus.md_use_d = 1'b1;
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = 3'd4; bus.src_a = 32'h12345678;
    #1;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL mthi_stall got=%b exp=0", bus.stall); end
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = 3'd5; bus.src_a = 32'hCAFEF00D;
    #1;
    checks++; if (bus.hi !== 32'h12345678) begin failures++; $display("FAIL mthi_hi got=%h exp=12345678", bus.hi); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mthi_busy got=%b exp=0", bus.busy); end
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    checks++; if (bus.lo !== 32'hCAFEF00D) begin failures++; $display("FAIL mtlo_lo got=%h exp=cafef00d", bus.lo); end
    bus.md_use_d = 1'b0;
    // starts arriving while busy must not disturb the in-flight MULT
    issue(3'd0, 32'd2, 32'd3);
    bus.start = 1'b1; bus.md_op = 3'd4; bus.src_a = 32'hDEADBEEF;
    @(negedge clk);
    bus.md_op = 3'd0; bus.src_a = 32'd100; bus.src_b = 32'd100;
    #1;
    checks++; if (bus.hi !== 32'h12345678) begin failures++; $display("FAIL busy_mthi_hi got=%h exp=12345678", bus.hi); end
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    count_busy(n);
    checks++; if (n !== 3) begin failures++; $display("FAIL busy_ignore_cnt got=%0d exp=3", n); end
    checks++; if (bus.lo !== 32'd6) begin failures++; $display("FAIL busy_ignore_lo got=%h exp=00000006", bus.lo); end
    checks++; if (bus.hi !== 32'd0) begin failures++; $display("FAIL busy_ignore_hi got=%h exp=0", bus.hi); end
  endtask

  task automatic test_reset_busy;
    int n;
`ifdef MD_SCHED_DIV_EN
    issue(3'd2, 32'd100, 32'd7);
`else
    issue(3'd0, 32'd5, 32'd7);
`endif
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL rb_prebusy got=%b exp=1", bus.busy); end
    reset = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rb_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL rb_hi got=%h exp=0", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin failures++; $display("FAIL rb_lo got=%h exp=0", bus.lo); end
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    checks++; if ({bus.hi, bus.lo} !== 64'h0) begin failures++; $display("FAIL rb_nowrite got=%h exp=0", {bus.hi, bus.lo}); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rb_idle got=%b exp=0", bus.busy); end
    // start presented alongside release is taken on the first edge with reset high
    @(negedge clk);
    reset = 1'b0;
    #2;
    bus.start = 1'b1; bus.md_op = 3'd0; bus.src_a = 32'd3; bus.src_b = 32'd3;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    count_busy(n);
    checks++; if (n !== 5) begin failures++; $display("FAIL rel_busy got=%0d exp=5", n); end
    checks++; if (bus.lo !== 32'd9) begin failures++; $display("FAIL rel_lo got=%h exp=00000009", bus.lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_stall();
    test_mthi();
    test_reset_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
